// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line encoder.
package usb_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 8;
    localparam int MAX_ONES         = 6;

    // {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_SE0_A,
        ST_SE0_B,
        ST_EOP_J
    } tx_enc_state_t;

    function automatic logic [1:0] line_of(input tx_enc_state_t st, input logic lvl_j);
        case (st)
            ST_SE0_A, ST_SE0_B: return LINE_SE0;
            ST_DATA, ST_STUFF:  return lvl_j ? LINE_J : LINE_K;
            default:            return LINE_J;
        endcase
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Modulo-CLKS_PER_BIT cycle counter; o_boundary flags the last cycle of a bit period.
module usb_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_boundary
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_boundary = (r_count == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB serial line encoder: bit timing, NRZI, bit stuffing and SE0/SE0/J end-of-packet.
// Bit stuffing is built only when USB_TX_BIT_STUFF_EN is defined.
//
// state    | meaning
// IDLE     | line J, counters clear, waiting for enable
// DATA     | driving a consumed data bit
// STUFF    | driving an inserted stuff bit (no tx_bit consumed)
// SE0_A/B  | two SE0 bit periods of the EOP
// EOP_J    | final J bit period of the EOP
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic tx_bit,
    input  logic eop,
    output logic bit_tick,
    output logic stuffing,
    output logic dplus,
    output logic dminus,
    output logic eop_done,
    output logic busy
);

    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    tx_enc_state_t    r_state, w_next_state;
    logic             r_level, w_next_level;
    logic             r_eop_pend, r_eop_done, r_busy;
    logic [1:0]       r_line;
    logic             w_eop_clr, w_tick, w_stuff_due, w_timer_clr, w_boundary;
    logic [CNT_W-1:0] w_count;

    assign w_timer_clr = (r_state == ST_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timer_clr),
        .o_count    (w_count),
        .o_boundary (w_boundary)
    );

`ifdef USB_TX_BIT_STUFF_EN
    logic [2:0] r_ones, w_next_ones;
    logic       r_stuffing, w_to_stuff;

    assign w_stuff_due = (r_ones == 3'(MAX_ONES));
    assign w_to_stuff  = w_boundary && w_stuff_due &&
                         ((r_state == ST_DATA) || (r_state == ST_STUFF));

    always_comb begin
        w_next_ones = r_ones;
        if (r_state == ST_IDLE) begin
            w_next_ones = (enable && tx_bit) ? 3'd1 : 3'd0;
        end else if (w_to_stuff) begin
            w_next_ones = 3'd0;
        end else if (w_tick) begin
            w_next_ones = tx_bit ? (r_ones + 3'd1) : 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones     <= 3'd0;
            r_stuffing <= 1'b0;
        end else begin
            r_ones     <= w_next_ones;
            r_stuffing <= (w_next_state == ST_STUFF);
        end
    end

    assign stuffing = r_stuffing;
`else
    assign w_stuff_due = 1'b0;
    assign stuffing    = 1'b0;
`endif

    // r_level: 1 = J, 0 = K. A consumed 0 toggles the line, a 1 holds it.
    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        w_tick       = 1'b0;
        w_eop_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_level = 1'b1;
                if (enable) begin
                    w_tick       = 1'b1;
                    w_next_state = ST_DATA;
                    if (!tx_bit) w_next_level = 1'b0;
                end
            end
            ST_DATA, ST_STUFF: begin
                if (w_boundary) begin
                    if (w_stuff_due) begin
                        w_next_state = ST_STUFF;
                        w_next_level = ~r_level;
                    end else if (r_eop_pend || !enable) begin
                        w_next_state = ST_SE0_A;
                        w_eop_clr    = 1'b1;
                        w_next_level = 1'b1;
                    end else begin
                        w_tick       = 1'b1;
                        w_next_state = ST_DATA;
                        if (!tx_bit) w_next_level = ~r_level;
                    end
                end
            end
            ST_SE0_A: if (w_boundary) w_next_state = ST_SE0_B;
            ST_SE0_B: if (w_boundary) w_next_state = ST_EOP_J;
            ST_EOP_J: if (w_boundary) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_level    <= 1'b1;
            r_line     <= LINE_J;
            r_busy     <= 1'b0;
            r_eop_done <= 1'b0;
            r_eop_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_level    <= w_next_level;
            r_line     <= line_of(w_next_state, w_next_level);
            r_busy     <= (w_next_state != ST_IDLE);
            r_eop_done <= (r_state == ST_EOP_J) && (w_count == CNT_PRE_LAST);
            // A new request in the same cycle as the clear must not be lost.
            if (eop && (r_state != ST_IDLE)) begin
                r_eop_pend <= 1'b1;
            end else if (w_eop_clr) begin
                r_eop_pend <= 1'b0;
            end
        end
    end

    assign bit_tick = w_tick;
    assign dplus    = r_line[1];
    assign dminus   = r_line[0];
    assign busy     = r_busy;
    assign eop_done = r_eop_done;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: a per-bit-period packet model expands into a per-cycle trace.
module tb_usb_tx_encoder;

    localparam int N   = 8;
    localparam int GAP = 3;
`ifdef USB_TX_BIT_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic tx_bit = 1'b0;
    logic eop = 1'b0;
    logic bit_tick, stuffing, dplus, dminus, eop_done, busy;

    int checks = 0;
    int errors = 0;
    int tr_idx = 0;

    logic [5:0] exp_q[$];
    bit         pkt[$];

    typedef struct {
        logic [1:0] line;
        bit         stuff;
        bit         data;
        bit         eopj;
    } per_t;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tx_bit   (tx_bit),
        .eop      (eop),
        .bit_tick (bit_tick),
        .stuffing (stuffing),
        .dplus    (dplus),
        .dminus   (dminus),
        .eop_done (eop_done),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [5:0] ent(input logic [1:0] line, input bit tick, input bit stf,
                                       input bit bsy, input bit done);
        return {line, tick, stf, bsy, done};
    endfunction

    task automatic push_idle(input int cycles);
        for (int i = 0; i < cycles; i++) exp_q.push_back(ent(J, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic add_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) pkt.push_back(v[i]);
    endtask

    // Reference: list of line periods from the USB rules, then one entry per clock.
    task automatic build_expect();
        per_t pers[$];
        bit   lvl_j;
        int   ones;
        bit   last, nxt_data;
        lvl_j = 1'b1;
        ones  = 0;
        foreach (pkt[i]) begin
            if (pkt[i]) ones++;
            else begin
                lvl_j = ~lvl_j;
                ones  = 0;
            end
            pers.push_back('{lvl_j ? J : K, 1'b0, 1'b1, 1'b0});
            if (STUFF_EN && ones == 6) begin
                lvl_j = ~lvl_j;
                ones  = 0;
                pers.push_back('{lvl_j ? J : K, 1'b1, 1'b0, 1'b0});
            end
        end
        pers.push_back('{SE0, 1'b0, 1'b0, 1'b0});
        pers.push_back('{SE0, 1'b0, 1'b0, 1'b0});
        pers.push_back('{J, 1'b0, 1'b0, 1'b1});
        exp_q.push_back(ent(J, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int p = 0; p < pers.size(); p++) begin
            nxt_data = (p + 1 < pers.size()) ? pers[p+1].data : 1'b0;
            for (int c = 0; c < N; c++) begin
                last = (c == N - 1);
                exp_q.push_back(ent(pers[p].line, last && nxt_data, pers[p].stuff, 1'b1,
                                    last && pers[p].eopj));
            end
        end
        push_idle(1 + GAP);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 8'(exp_q.size() != 0), 8'd0);
        exp_q.delete();
    endtask

    // Emulates the shift register and control FSM; ends the packet by eop or by dropping enable.
    task automatic run_packet(input bit abort_mode, input int off);
        int idx, since, budget;
        bit tick_seen, done_seen, fin;
        build_expect();
        enable = 1'b1;
        tx_bit = pkt[0];
        idx    = 0;
        since  = -1;
        fin    = 1'b0;
        budget = (pkt.size() * 2 + 6) * N;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            tick_seen = bit_tick;
            done_seen = eop_done;
            if (done_seen) begin
                enable = 1'b0;
                fin    = 1'b1;
            end
            @(posedge clk);
            #1;
            eop = 1'b0;
            if (tick_seen) begin
                idx++;
                tx_bit = (idx < pkt.size()) ? pkt[idx] : 1'($urandom);
                if (idx == pkt.size()) since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (!fin && since == off) begin
                if (abort_mode) enable = 1'b0;
                else eop = 1'b1;
            end
        end
        eop = 1'b0;
        chk("eop_done_seen", 8'(fin), 8'd1);
        if (!fin) begin
            exp_q.delete();
            enable = 1'b0;
            rst    = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            wait_drain();
        end
    endtask

    initial begin : monitor
        logic [5:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {dplus, dminus, bit_tick, stuffing, busy, eop_done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL trace[%0d] {dp,dm,tick,stuff,busy,done} actual=%b required=%b",
                             tr_idx, a, e);
                end
                tr_idx++;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog timeout");
    end

    initial begin : stimulus
        repeat (3) begin
            @(negedge clk);
            chk("reset_line", {6'b0, dplus, dminus}, {6'b0, J});
            chk("reset_flags", {4'b0, bit_tick, stuffing, busy, eop_done}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_idle(2 * N);
        wait_drain();

        pkt.delete(); add_bits(32'h80, 8);
        run_packet(1'b0, 3);

        pkt.delete(); add_bits(32'h80, 8); add_bits(32'hFE, 8);
        run_packet(1'b0, 3);

        pkt.delete(); add_bits(32'h80, 8); add_bits(32'h1F, 5);
        run_packet(1'b0, 3);

        pkt.delete(); add_bits(32'h80, 8); add_bits(32'hA5, 8);
        run_packet(1'b1, 2);

        for (int p = 0; p < 24; p++) begin
            int n;
            n = $urandom_range(8, 40);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
            run_packet(1'($urandom_range(0, 1)), $urandom_range(0, N - 2));
        end

        enable = 1'b1;
        tx_bit = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (N + 3) @(posedge clk);
        #1;
        chk("se0_line", {6'b0, dplus, dminus}, {6'b0, SE0});
        chk("se0_busy", {7'b0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_se0_line", {6'b0, dplus, dminus}, {6'b0, J});
        chk("rst_mid_se0_flags", {4'b0, bit_tick, stuffing, busy, eop_done}, 8'd0);
        @(negedge clk);
        chk("rst_held_line", {6'b0, dplus, dminus}, {6'b0, J});
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_idle(N);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Serial line encoder for the USB transmit path, downstream of the transmit control FSM and its parallel-to-serial shift register. It owns the bit-period timing, consumes one serial bit per bit period, and applies NRZI encoding and bit stuffing. It drives the differential pair, including the SE0/SE0/J end-of-packet sequence. It returns `bit_tick` and `stuffing` so the upstream FSM and shift register advance only on real data bits.

## Interface
- `CLKS_PER_BIT`, 8, clock cycles per USB bit period (≥2)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  packet in progress, held high by control FSM from start of SYNC until EOP requested
- `tx_bit`  in  1  current serial bit from shift register (LSB-first), sampled only on `bit_tick` cycles
- `eop`  in  1  one-cycle EOP request pulse; latched
- `bit_tick`  out  1  one-cycle pulse: `tx_bit` consumed this cycle; shift register advances
- `stuffing`  out  1  high for every cycle of a stuff-bit period
- `dplus`, `dminus`  out  1 each  line outputs: J = 1/0, K = 0/1, SE0 = 0/0
- `eop_done`  out  1  one-cycle pulse on last cycle of the EOP J period
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, STUFF, SE0_A, SE0_B, EOP_J.
- Registers:
  - `cycle_cnt`: 0..CLKS_PER_BIT-1.
  - `ones_cnt`: 0..6.
  - `level`: current NRZI level, J or K.
  - `eop_pend`.
- IDLE: line drives J; counters are cleared.
  - When `enable`=1, that cycle is a boundary: `bit_tick`=1 and `tx_bit` is consumed.
  - Go to DATA.
- Boundary cycle (`cycle_cnt`==CLKS_PER_BIT-1 in DATA or STUFF) selects what the next period carries. Priority, highest first:
  1. `ones_cnt`==6: go to STUFF; toggle `level`; `ones_cnt`←0; no `bit_tick`.
  2. `eop_pend`=1 or `enable`=0: go to SE0_A; clear `eop_pend`; no `bit_tick`.
  3. Otherwise: go to DATA; `bit_tick`=1.
     - `tx_bit`=0: toggle `level`; `ones_cnt`←0.
     - `tx_bit`=1: hold `level`; `ones_cnt`++.
- Consumption rule: `tx_bit`=0 toggles the line, 1 holds it; the new level appears from the following cycle.
- `eop_pend` set:
  - Set by `eop`=1 in any non-IDLE state; ignored in IDLE.
  - Set and clear in the same cycle: set wins.
- SE0_A and SE0_B each last one bit period driving SE0. EOP_J lasts one period driving J.
  - `eop_done` pulses on the last EOP_J cycle, then the block goes to IDLE.
  - `enable` is ignored during the EOP sequence.
- `stuffing` is a registered state decode (STUFF): high exactly CLKS_PER_BIT cycles per stuff bit.
- `ones_cnt` counts across byte boundaries; it resets only on a consumed 0, a stuff bit, or IDLE.

## Timing
- Reset values:
  - `dplus`=1, `dminus`=0.
  - `bit_tick`=0, `stuffing`=0, `eop_done`=0, `busy`=0.
  - State IDLE, `level`=J, all counters 0, `eop_pend`=0.
- `bit_tick` is combinational from state/counter; all other outputs are registered.
- Line change latency: one cycle after the boundary cycle.
- Data bit periods: `bit_tick` repeats every CLKS_PER_BIT cycles. A stuff period inserts one extra period with no tick.
- Stuff due and EOP due on the same boundary: the stuff period comes first, then SE0 at the next boundary.
- EOP total: 3·CLKS_PER_BIT cycles from leaving DATA/STUFF to `eop_done`. IDLE follows on the next cycle.
- `rst` asserted mid-operation: immediate return to the reset values, including J on the line.

## Configuration
- `USB_TX_BIT_STUFF_EN`:
  - Defined: bit stuffing as specified.
  - Undefined: `ones_cnt` logic and the STUFF state are removed, `stuffing` is tied 0, and no stuff bits are inserted (debug/loopback builds only).

## Structure
- Shared package `usb_tx_pkg` holds:
  - state enum `tx_enc_state_t`.
  - line-encoding constants `LINE_J`, `LINE_K`, `LINE_SE0` (2-bit {dplus,dminus}).
  - `MAX_ONES`=6.
  - default `CLKS_PER_BIT`.
- One sub-module, `usb_bit_timer`: parameterized modulo-CLKS_PER_BIT counter with clear and a boundary flag. The encoder FSM, NRZI, and stuffing logic stay in the top module.

## Test plan
- Reset: hold `rst`=1 mid-period → `dplus`/`dminus`=1/0, `busy`=0, no pulses; release → remains IDLE while `enable`=0.
- SYNC: `enable`=1, feed bits 0,0,0,0,0,0,0,1 → line K,J,K,J,K,J,K,K; `bit_tick` every 8 cycles; `stuffing`=0.
- Stuffing: feed 0 then seven 1s → after the sixth 1, `stuffing`=1 for exactly 8 cycles with the line toggled and no `bit_tick`; the seventh 1 is consumed after it with the line held.
- EOP: `eop` pulse at cycle 3 of a data period → period finishes; SE0 for 16 cycles, J for 8; `eop_done` pulse; `busy`=0 the next cycle.
- Stuff+EOP collision: six 1s with `eop` pulsed during the sixth → an 8-cycle stuff period precedes the SE0.
- Abort: `enable` dropped mid-packet without `eop` → EOP sequence starts at the next boundary; `rst` mid-SE0 → J immediately.
